// File: rtl/switch_press_repeat_if.sv
// Switch signal bundle: raw button level in, debounced level and
// press/release/repeat strobes out.
//
// There is no valid/ready handshake here. i_Switch is a free-running
// asynchronous level. Every output is a registered level or a
// single-cycle strobe, valid on every clock once reset is released.
interface switch_press_repeat_if;
   logic i_Switch;
   logic o_Switch;
   logic o_Press_Pulse;
   logic o_Release_Pulse;
   logic o_Repeating;

   // The design side receives the raw switch and drives the results.
   modport slave (
      input  i_Switch,
      output o_Switch,
      output o_Press_Pulse,
      output o_Release_Pulse,
      output o_Repeating
   );

   // The environment side drives the raw switch and observes the results.
   modport master (
      output i_Switch,
      input  o_Switch,
      input  o_Press_Pulse,
      input  o_Release_Pulse,
      input  o_Repeating
   );
endinterface

// File: rtl/switch_press_repeat.sv
// Push-button front end. The raw level goes through a two-flop
// synchronizer and a debouncer. A press/hold/auto-repeat FSM then emits
// one press strobe on the initial press and one per repeat period while
// the button is held. It emits one release strobe when the debounced
// level falls. o_dbg_state exposes the FSM state for observation.
module switch_press_repeat #(
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int HOLD_LIMIT     = 12500000,
   parameter int REPEAT_LIMIT   = 2500000
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   switch_press_repeat_if.slave sw,
   output logic [1:0]           o_dbg_state
);

   localparam int MAX_DH    = (DEBOUNCE_LIMIT > HOLD_LIMIT) ? DEBOUNCE_LIMIT : HOLD_LIMIT;
   localparam int MAX_LIMIT = (MAX_DH > REPEAT_LIMIT) ? MAX_DH : REPEAT_LIMIT;
   localparam int CW        = $clog2(MAX_LIMIT) + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_e;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] deb_cnt_q, deb_cnt_d;
   logic          switch_q, switch_d;
   state_e        state_q, state_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          repeating_q, repeating_d;

   logic          differ;
   logic          accept;
   logic          rise;
   logic          fall;

   // Synchronizer and debouncer: count consecutive cycles where the
   // synchronized level disagrees with the accepted one, and flip the
   // accepted level once the disagreement has lasted DEBOUNCE_LIMIT cycles.
   always_comb begin
      sync1_d   = sw.i_Switch;
      sync2_d   = sync1_q;
      deb_cnt_d = '0;
      switch_d  = switch_q;
      differ    = (sync2_q != switch_q);
      accept    = differ && (deb_cnt_q == CW'(DEBOUNCE_LIMIT - 1));
      if (accept) begin
         switch_d = ~switch_q;
      end else if (differ) begin
         deb_cnt_d = deb_cnt_q + 1'b1;
      end
      rise = accept && !switch_q;
      fall = accept &&  switch_q;
   end

   // FSM next state and strobes. Rise and fall are decoded from the
   // same accept condition that flips o_Switch, so the press strobe
   // lands in the same cycle that o_Switch first reads 1. A fall beats
   // any repeat expiry that happens in the same cycle.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            hold_cnt_d = '0;
            if (rise) begin
               state_d = DELAY;
               press_d = 1'b1;
            end
         end
         DELAY: begin
            if (fall) begin
               state_d    = IDLE;
               hold_cnt_d = '0;
               release_d  = 1'b1;
            end else if (hold_cnt_q == CW'(HOLD_LIMIT - 1)) begin
               state_d    = REPEAT;
               hold_cnt_d = '0;
               press_d    = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         REPEAT: begin
            if (fall) begin
               state_d    = IDLE;
               hold_cnt_d = '0;
               release_d  = 1'b1;
            end else if (hold_cnt_q == CW'(REPEAT_LIMIT - 1)) begin
               hold_cnt_d = '0;
               press_d    = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = '0;
         end
      endcase
      repeating_d = (state_d == REPEAT);
   end

   // State register for the synchronizer, debouncer, FSM and all outputs.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         deb_cnt_q   <= '0;
         switch_q    <= 1'b0;
         state_q     <= IDLE;
         hold_cnt_q  <= '0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         repeating_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_cnt_q   <= deb_cnt_d;
         switch_q    <= switch_d;
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         press_q     <= press_d;
         release_q   <= release_d;
         repeating_q <= repeating_d;
      end
   end

   assign sw.o_Switch        = switch_q;
   assign sw.o_Press_Pulse   = press_q;
   assign sw.o_Release_Pulse = release_q;
   assign sw.o_Repeating     = repeating_q;
   assign o_dbg_state        = state_q;

endmodule
